// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - sprite/screen pixel walker with mask, clipping and done pulse
module sprite_blitter #(
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int COLOR_W  = 3,
    parameter int SPR_W    = 4,
    parameter int SPR_H    = 4,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter logic [COLOR_W-1:0]     FG_COLOR    = 3'b100,
    parameter logic [COLOR_W-1:0]     BG_COLOR    = 3'b011,
    parameter logic [COLOR_W-1:0]     CLEAR_COLOR = 3'b111,
    parameter logic [SPR_W*SPR_H-1:0] SPRITE_MASK = '1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [X_W-1:0]     x_in,
    input  logic [Y_W-1:0]     y_in,
    output logic               busy,
    output logic               done,
    output logic               plot,
    output logic [X_W-1:0]     x_out,
    output logic [Y_W-1:0]     y_out,
    output logic [COLOR_W-1:0] color_out
);

    localparam logic [1:0] MODE_DRAW  = 2'd0;
    localparam logic [1:0] MODE_ERASE = 2'd1;
    localparam logic [1:0] MODE_CLEAR = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    localparam int MASK_N = SPR_W * SPR_H;

    // Screen limits widened by one bit so the carry of x0+col takes part in the compare
    localparam logic [X_W:0] X_LIM = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(SCREEN_H);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [X_W-1:0]     x0, x0_nx, col, col_nx;
    logic [Y_W-1:0]     y0, y0_nx, row, row_nx;
    logic [1:0]         mode_r, mode_nx;
    logic [COLOR_W-1:0] color_r, color_nx;

    logic               plot_nx, busy_nx, done_nx;
    logic [X_W-1:0]     x_out_nx;
    logic [Y_W-1:0]     y_out_nx;
    logic [COLOR_W-1:0] color_out_nx;

    logic [X_W-1:0]     w_m1;
    logic [Y_W-1:0]     h_m1;
    logic [X_W:0]       x_sum;
    logic [Y_W:0]       y_sum;
    logic [8:0]         mask_idx;
    logic               in_bounds;
    logic               opaque;

    // Box extent, pixel position and visibility of the pixel at (col,row)
    always_comb begin
        w_m1      = (mode_r == MODE_CLEAR) ? X_W'(SCREEN_W - 1) : X_W'(SPR_W - 1);
        h_m1      = (mode_r == MODE_CLEAR) ? Y_W'(SCREEN_H - 1) : Y_W'(SPR_H - 1);
        x_sum     = {1'b0, x0} + {1'b0, col};
        y_sum     = {1'b0, y0} + {1'b0, row};
        in_bounds = (x_sum < X_LIM) && (y_sum < Y_LIM);
        // Only the low 4 bits matter: the mask is consulted in draw mode, where col/row < 16
        mask_idx  = 9'(row[3:0]) * 9'(SPR_W) + 9'(col[3:0]);
        opaque    = (mode_r != MODE_DRAW) ||
                    (|(SPRITE_MASK & (MASK_N'(1) << mask_idx)));
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, walk counters and next registered pixel outputs
    always_comb begin
        state_nx     = state;
        x0_nx        = x0;
        y0_nx        = y0;
        mode_nx      = mode_r;
        color_nx     = color_r;
        col_nx       = col;
        row_nx       = row;
        plot_nx      = 1'b0;
        x_out_nx     = x_out;
        y_out_nx     = y_out;
        color_out_nx = color_out;

        case (state)
            S_IDLE: begin
                if (start && (mode != MODE_RSVD)) begin
                    x0_nx    = (mode == MODE_CLEAR) ? '0 : x_in;
                    y0_nx    = (mode == MODE_CLEAR) ? '0 : y_in;
                    mode_nx  = mode;
                    color_nx = (mode == MODE_DRAW)  ? FG_COLOR :
                               (mode == MODE_ERASE) ? BG_COLOR : CLEAR_COLOR;
                    col_nx   = '0;
                    row_nx   = '0;
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                x_out_nx     = x_sum[X_W-1:0];
                y_out_nx     = y_sum[Y_W-1:0];
                color_out_nx = color_r;
                plot_nx      = in_bounds && opaque;
                if (col == w_m1) begin
                    col_nx = '0;
                    if (row == h_m1) begin
                        state_nx = S_DONE;
                    end else begin
                        row_nx = row + 1'b1;
                    end
                end else begin
                    col_nx = col + 1'b1;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        busy_nx = (state_nx != S_IDLE);
        done_nx = (state_nx == S_DONE);
    end

    // Latched request, walk counters and registered VGA-side outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            x0        <= '0;
            y0        <= '0;
            mode_r    <= '0;
            color_r   <= '0;
            col       <= '0;
            row       <= '0;
            plot      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            color_out <= '0;
        end else begin
            x0        <= x0_nx;
            y0        <= y0_nx;
            mode_r    <= mode_nx;
            color_r   <= color_nx;
            col       <= col_nx;
            row       <= row_nx;
            plot      <= plot_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            x_out     <= x_out_nx;
            y_out     <= y_out_nx;
            color_out <= color_out_nx;
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - directed self-checking bench for sprite_blitter
module tb_sprite_blitter;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] start_v;
    logic [1:0] mode;
    logic [8:0] x_in;
    logic [7:0] y_in;

    logic [2:0] busy_v, done_v, plot_v;
    logic [8:0] x_v [3];
    logic [7:0] y_v [3];
    logic [2:0] c_v [3];

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    sprite_blitter u_dut (
        .clock(clock), .reset(reset), .start(start_v[0]), .mode(mode),
        .x_in(x_in), .y_in(y_in), .busy(busy_v[0]), .done(done_v[0]),
        .plot(plot_v[0]), .x_out(x_v[0]), .y_out(y_v[0]), .color_out(c_v[0])
    );

    sprite_blitter #(.SPRITE_MASK(16'h8421)) u_msk (
        .clock(clock), .reset(reset), .start(start_v[1]), .mode(mode),
        .x_in(x_in), .y_in(y_in), .busy(busy_v[1]), .done(done_v[1]),
        .plot(plot_v[1]), .x_out(x_v[1]), .y_out(y_v[1]), .color_out(c_v[1])
    );

    sprite_blitter #(.SCREEN_W(8), .SCREEN_H(4)) u_clr (
        .clock(clock), .reset(reset), .start(start_v[2]), .mode(mode),
        .x_in(x_in), .y_in(y_in), .busy(busy_v[2]), .done(done_v[2]),
        .plot(plot_v[2]), .x_out(x_v[2]), .y_out(y_v[2]), .color_out(c_v[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_quiet(input string tag, input int sel, input logic zero_xy);
        chk({tag, "_busy"}, busy_v[sel], 0);
        chk({tag, "_done"}, done_v[sel], 0);
        chk({tag, "_plot"}, plot_v[sel], 0);
        if (zero_xy) begin
            chk({tag, "_x"}, x_v[sel], 0);
            chk({tag, "_y"}, y_v[sel], 0);
            chk({tag, "_c"}, c_v[sel], 0);
        end
    endtask

    // Accept a request in the current IDLE cycle, then check every cycle up to the IDLE after DONE
    task automatic walk(input string name, input int sel, input logic [1:0] md,
                        input int xi, input int yi, input int sw, input int sh,
                        input logic [31:0] mask, input int exp_plots);
        int w, h, ox, oy, n, c, r, xe, ye, nplot;
        logic ep;
        logic [2:0] ecol;
        w    = (md == 2) ? sw : 4;
        h    = (md == 2) ? sh : 4;
        ox   = (md == 2) ? 0 : xi;
        oy   = (md == 2) ? 0 : yi;
        n    = w * h;
        ecol = (md == 0) ? 3'b100 : (md == 1) ? 3'b011 : 3'b111;
        nplot = 0;

        mode = md;
        x_in = 9'(xi);
        y_in = 8'(yi);
        start_v[sel] = 1'b1;
        tick();
        chk({name, "_c1_busy"}, busy_v[sel], 1);
        chk({name, "_c1_plot"}, plot_v[sel], 0);
        // Inputs and start disturbed during RUN must not affect the walk
        mode = 2'd2;
        x_in = 9'h155;
        y_in = 8'haa;
        for (int k = 0; k < n; k++) begin
            tick();
            if (k == 0) start_v[sel] = 1'b0;
            c  = k % w;
            r  = k / w;
            xe = ox + c;
            ye = oy + r;
            ep = (xe < sw) && (ye < sh) && ((md != 0) || mask[r * w + c]);
            chk($sformatf("%s_p%0d_plot", name, k), plot_v[sel], ep);
            chk($sformatf("%s_p%0d_x", name, k), x_v[sel], xe & 511);
            chk($sformatf("%s_p%0d_y", name, k), y_v[sel], ye & 255);
            chk($sformatf("%s_p%0d_c", name, k), c_v[sel], ecol);
            chk($sformatf("%s_p%0d_done", name, k), done_v[sel], (k == n - 1));
            chk($sformatf("%s_p%0d_busy", name, k), busy_v[sel], 1);
            if (plot_v[sel] === 1'b1) nplot++;
        end
        chk({name, "_plots"}, nplot, exp_plots);
        tick();
        chk_quiet({name, "_idle"}, sel, 1'b0);
    endtask

    initial begin
        reset   = 1'b1;
        start_v = '0;
        mode    = 2'd0;
        x_in    = '0;
        y_in    = '0;
        tick();
        tick();
        for (int i = 0; i < 3; i++) chk_quiet($sformatf("rst%0d", i), i, 1'b1);
        reset = 1'b0;
        tick();

        walk("draw",   0, 2'd0, 10,  20,  320, 240, 32'hffff, 16);
        walk("erase",  0, 2'd1, 318, 238, 320, 240, 32'hffff, 4);
        walk("mdraw",  1, 2'd0, 0,   0,   320, 240, 32'h8421, 4);
        walk("merase", 1, 2'd1, 0,   0,   320, 240, 32'h8421, 16);
        walk("clear",  2, 2'd2, 100, 50,  8,   4,   32'hffff, 32);

        // Reset while pixel 5 of a draw is on the outputs
        mode = 2'd0;
        x_in = 9'd10;
        y_in = 8'd20;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (6) tick();
        chk("mid_p5_plot", plot_v[0], 1);
        chk("mid_p5_x", x_v[0], 11);
        chk("mid_p5_y", y_v[0], 21);
        reset = 1'b1;
        tick();
        chk_quiet("mid_rst", 0, 1'b1);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_quiet($sformatf("post_rst%0d", i), 0, 1'b0);
        end
        walk("redraw", 0, 2'd0, 10, 20, 320, 240, 32'hffff, 16);

        // Reserved mode is never accepted
        mode = 2'd3;
        start_v[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_quiet($sformatf("rsvd%0d", i), 0, 1'b0);
        end
        start_v[0] = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
